// File: rtl/tc_display_formatter.sv
// tc_display_formatter
//   Sequential back end of the calculator datapath. Captures a two's-complement
//   ALU result, produces its sign, a signed-magnitude copy and packed BCD
//   digits (iterative double-dabble, one bit per clock) plus leading-zero
//   blanking flags for the 7-segment driver. Start/busy/done handshake.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     start     request conversion; sampled only in IDLE
//     tc_in     two's-complement value, captured at start
//     busy      high while shifting
//     done      one-cycle pulse when outputs are updated
//     sign      1 = negative result
//     sm_out    signed-magnitude form of tc_in
//     overflow  tc_in was the most-negative value (no SM form exists)
//     bcd       magnitude in BCD, digit 0 in bits [3:0]
//     blank     1 = leading zero to blank; bit 0 is always 0
module tc_display_formatter #(
    parameter int width  = 11,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [width-1:0]      tc_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [width-1:0]      sm_out,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CW = $clog2(width + 1);

    logic [1:0]          state;
    logic [width-1:0]    mag_sh;
    logic [width-1:0]    mag_orig;
    logic                sign_r;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_adj;
    logic [DIGITS-1:0]   blank_nxt;
    logic                higher_zero;
    logic [CW-1:0]       cnt;
    logic [width-1:0]    tc_neg;
    logic [width-1:0]    most_neg;

    assign tc_neg   = '0 - tc_in;
    assign most_neg = {1'b1, {(width-1){1'b0}}};
    assign busy     = (state == SHIFT);

    // Double-dabble correction: any digit >= 5 gets +3 before the shift so it
    // carries correctly into the next decade.
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked only if it and every higher digit are zero; the
    // least-significant digit is always shown.
    always_comb begin
        blank_nxt   = '0;
        higher_zero = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            higher_zero  = higher_zero & (scratch[4*i +: 4] == 4'd0);
            blank_nxt[i] = higher_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mag_sh   <= '0;
            mag_orig <= '0;
            sign_r   <= 1'b0;
            scratch  <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            sign     <= 1'b0;
            sm_out   <= '0;
            overflow <= 1'b0;
            bcd      <= '0;
            blank    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r   <= tc_in[width-1];
                        mag_sh   <= tc_in[width-1] ? tc_neg : tc_in;
                        mag_orig <= tc_in[width-1] ? tc_neg : tc_in;
                        scratch  <= '0;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, mag_sh} <= {scratch_adj[4*DIGITS-2:0], mag_sh, 1'b0};
                    cnt               <= cnt + CW'(1);
                    if (cnt == CW'(width - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= scratch;
                    blank    <= blank_nxt;
                    sign     <= sign_r;
                    sm_out   <= {sign_r, mag_orig[width-2:0]};
                    overflow <= sign_r & (mag_orig == most_neg);
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
